// File: rtl/microcode_pkg.sv
// Shared constants for the microcode sequencer: control-word bit positions,
// FSM state encoding and the interrupt pseudo-opcode table.
package microcode_pkg;

   localparam int unsigned CtrlW        = 65;
   localparam int unsigned UcAddrW      = 9;
   localparam int unsigned NumIrqSrc    = 5;

   // Sequencing bits in the ROM control word; bits below CtrlCbPrefix belong to the datapath.
   localparam int unsigned CtrlEnd      = 64;
   localparam int unsigned CtrlWaitMem  = 63;
   localparam int unsigned CtrlHalt     = 62;
   localparam int unsigned CtrlCbPrefix = 61;

   typedef enum logic [2:0] {
      StFetch,
      StExec,
      StCbFetch,
      StHalted,
      StIrq
   } state_e;

   // Unused GB opcodes reused as interrupt entry points, index 0 = VBlank .. 4 = Joypad.
   localparam logic [NumIrqSrc-1:0][7:0] IrqOpc = {8'hE4, 8'hE3, 8'hDD, 8'hDB, 8'hD3};

endpackage

// File: rtl/microcode_sequencer_irq_priority_enc.sv
// Lowest-set-bit priority encoder for interrupt requests.
// Ports:
//   req_i    : request vector
//   idx_o    : index of the lowest set bit (0 when none set)
//   onehot_o : one-hot of the selected bit (0 when none set)
//   valid_o  : any request set
module irq_priority_enc #(
   parameter int unsigned NumIrq = 5,
   parameter int unsigned IdxW   = (NumIrq > 1) ? $clog2(NumIrq) : 1
) (
   input  logic [NumIrq-1:0] req_i,
   output logic [IdxW-1:0]   idx_o,
   output logic [NumIrq-1:0] onehot_o,
   output logic              valid_o
);

   logic found;

   always_comb begin
      idx_o    = '0;
      onehot_o = '0;
      found    = 1'b0;
      for (int i = 0; i < int'(NumIrq); i++) begin
         if (req_i[i] && !found) begin
            idx_o       = IdxW'(i);
            onehot_o[i] = 1'b1;
            found       = 1'b1;
         end
      end
      valid_o = |req_i;
   end

endmodule

// File: rtl/microcode_sequencer.sv
// Microcode sequencer: fetches opcode bytes (with CB prefix), addresses the
// microcode ROM with {cb, opcode} and a step counter, stalls on memory wait,
// and injects interrupt pseudo-opcodes / HALT at instruction boundaries.
// Ports:
//   clk, reset_n       : clock, synchronous active-low reset
//   mem_data_in        : fetched byte from bus interface
//   mem_ready          : bus transaction completes this cycle
//   ctrl_word          : ROM output for current uc_opcode/uc_step
//   ime, irq_pending   : interrupt master enable, requested&enabled sources
//   uc_opcode, uc_step : ROM address
//   fetch_req, pc_inc  : opcode fetch request, PC increment pulse
//   instr_done         : pulse on the last micro-op
//   irq_ack            : one-hot pulse for the serviced source
//   ucode_err          : sticky step-overflow flag
module microcode_sequencer
   import microcode_pkg::*;
#(
   parameter int unsigned StepW  = 3,
   parameter int unsigned NumIrq = 5
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic [7:0]         mem_data_in,
   input  logic               mem_ready,
   input  logic [CtrlW-1:0]   ctrl_word,
   input  logic               ime,
   input  logic [NumIrq-1:0]  irq_pending,
   output logic [UcAddrW-1:0] uc_opcode,
   output logic [StepW-1:0]   uc_step,
   output logic               fetch_req,
   output logic               pc_inc,
   output logic               instr_done,
   output logic [NumIrq-1:0]  irq_ack,
   output logic               ucode_err
);

   localparam int unsigned IdxW = (NumIrq > 1) ? $clog2(NumIrq) : 1;

   state_e           state_q;
   logic [7:0]       opcode_q;
   logic             cb_q;
   logic [StepW-1:0] step_q;
   logic             err_q;

   logic [IdxW-1:0]   irq_idx;
   logic [NumIrq-1:0] irq_onehot;
   logic              irq_valid;

   logic cw_end, cw_wait, cw_halt, cw_cb, stalled, fetching;
   logic unused_ctrl;

   irq_priority_enc #(
      .NumIrq (NumIrq),
      .IdxW   (IdxW)
   ) u_irq_enc (
      .req_i    (irq_pending),
      .idx_o    (irq_idx),
      .onehot_o (irq_onehot),
      .valid_o  (irq_valid)
   );

   assign cw_end      = ctrl_word[CtrlEnd];
   assign cw_wait     = ctrl_word[CtrlWaitMem];
   assign cw_halt     = ctrl_word[CtrlHalt];
   assign cw_cb       = ctrl_word[CtrlCbPrefix];
   assign unused_ctrl = ^ctrl_word[CtrlCbPrefix-1:0];
   assign stalled     = cw_wait && !mem_ready;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q  <= StFetch;
         opcode_q <= '0;
         cb_q     <= 1'b0;
         step_q   <= '0;
         err_q    <= 1'b0;
      end else begin
         case (state_q)
            StFetch, StCbFetch: begin
               if (mem_ready) begin
                  opcode_q <= mem_data_in;
                  cb_q     <= (state_q == StCbFetch);
                  step_q   <= '0;
                  state_q  <= StExec;
               end
            end
            StExec: begin
               if (stalled) begin
                  state_q <= StExec;
               end else if (cw_cb) begin
                  state_q <= StCbFetch;
               end else if (cw_halt) begin
                  state_q <= StHalted;
               end else if (cw_end) begin
                  state_q <= (ime && irq_valid) ? StIrq : StFetch;
               end else if (step_q == '1) begin
                  // Runaway microcode: flag it and park on the last step.
                  err_q <= 1'b1;
               end else begin
                  step_q <= step_q + StepW'(1);
               end
            end
            StHalted: begin
               // Wake ignores ime; ime only decides whether to service.
               if (irq_valid) begin
                  state_q <= ime ? StIrq : StFetch;
               end
            end
            StIrq: begin
               if (irq_valid) begin
                  opcode_q <= IrqOpc[irq_idx];
                  cb_q     <= 1'b0;
                  step_q   <= '0;
                  state_q  <= StExec;
               end else begin
                  state_q <= StFetch;
               end
            end
            default: state_q <= StFetch;
         endcase
      end
   end

   always_comb begin
      fetching   = (state_q == StFetch) || (state_q == StCbFetch);
      uc_opcode  = {cb_q, opcode_q};
      uc_step    = step_q;
      ucode_err  = err_q;
      fetch_req  = reset_n && fetching;
      pc_inc     = reset_n && fetching && mem_ready;
      instr_done = reset_n && (state_q == StExec) && !stalled && !cw_cb && (cw_halt || cw_end);
      irq_ack    = (reset_n && (state_q == StIrq)) ? irq_onehot : '0;
   end

endmodule

// File: tb/tb_microcode_sequencer.sv
module tb_microcode_sequencer;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [7:0]  mem_data_in;
   logic        mem_ready;
   logic [64:0] ctrl_word;
   logic        ime;
   logic [4:0]  irq_pending;
   logic [8:0]  uc_opcode;
   logic [2:0]  uc_step;
   logic        fetch_req, pc_inc, instr_done, ucode_err;
   logic [4:0]  irq_ack;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   microcode_sequencer #(
      .StepW  (3),
      .NumIrq (5)
   ) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .mem_data_in (mem_data_in),
      .mem_ready   (mem_ready),
      .ctrl_word   (ctrl_word),
      .ime         (ime),
      .irq_pending (irq_pending),
      .uc_opcode   (uc_opcode),
      .uc_step     (uc_step),
      .fetch_req   (fetch_req),
      .pc_inc      (pc_inc),
      .instr_done  (instr_done),
      .irq_ack     (irq_ack),
      .ucode_err   (ucode_err)
   );

   // Control word built from the sequencing fields only.
   function automatic logic [64:0] cw(input logic e, input logic w, input logic h, input logic c);
      cw = {e, w, h, c, 61'h0};
   endfunction

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Advance one clock; inputs are then changed 1 time unit after the edge.
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset_n = 1'b0; mem_data_in = 8'h00; mem_ready = 1'b1;
      ctrl_word = '0; ime = 1'b0; irq_pending = '0;
      #1;
      chk("rst_fetch_req", 16'(fetch_req), 16'h0);
      chk("rst_pc_inc", 16'(pc_inc), 16'h0);
      cyc();
      chk("rst_opcode", 16'(uc_opcode), 16'h000);
      chk("rst_step", 16'(uc_step), 16'h0);
      chk("rst_err", 16'(ucode_err), 16'h0);
      chk("rst_fetch_req2", 16'(fetch_req), 16'h0);
      reset_n = 1'b1;

      // NOP
      mem_data_in = 8'h00; mem_ready = 1'b1; ctrl_word = '0; #1;
      chk("nop_fetch_req", 16'(fetch_req), 16'h1);
      chk("nop_pc_inc", 16'(pc_inc), 16'h1);
      cyc();
      mem_ready = 1'b0; ctrl_word = cw(1, 0, 0, 0); #1;
      chk("nop_opcode", 16'(uc_opcode), 16'h000);
      chk("nop_step", 16'(uc_step), 16'h0);
      chk("nop_done", 16'(instr_done), 16'h1);
      chk("nop_exec_nofetch", 16'(fetch_req), 16'h0);
      cyc();
      ctrl_word = '0; #1;
      chk("nop_refetch", 16'(fetch_req), 16'h1);
      chk("nop_refetch_noinc", 16'(pc_inc), 16'h0);
      chk("nop_done_clr", 16'(instr_done), 16'h0);

      // CB-prefixed op
      mem_data_in = 8'hCB; mem_ready = 1'b1; #1;
      chk("cb_inc1", 16'(pc_inc), 16'h1);
      cyc();
      mem_ready = 1'b0; ctrl_word = cw(0, 0, 0, 1); #1;
      chk("cb_pfx_opcode", 16'(uc_opcode), 16'h0CB);
      chk("cb_pfx_nodone", 16'(instr_done), 16'h0);
      cyc();
      mem_data_in = 8'h37; mem_ready = 1'b1; ctrl_word = '0; #1;
      chk("cb_fetch_req", 16'(fetch_req), 16'h1);
      chk("cb_inc2", 16'(pc_inc), 16'h1);
      cyc();
      mem_ready = 1'b0; ctrl_word = cw(1, 0, 0, 0); #1;
      chk("cb_opcode", 16'(uc_opcode), 16'h137);
      chk("cb_step", 16'(uc_step), 16'h0);
      chk("cb_done", 16'(instr_done), 16'h1);
      cyc();

      // Memory stall: 3-step op, WAIT_MEM at step 1
      mem_data_in = 8'h40; mem_ready = 1'b1; ctrl_word = '0; #1;
      cyc();
      mem_ready = 1'b0; ctrl_word = '0; #1;
      chk("stall_step0", 16'(uc_step), 16'h0);
      cyc();
      ctrl_word = cw(0, 1, 0, 0);
      for (int i = 0; i < 4; i++) begin
         #1;
         chk("stall_hold", 16'(uc_step), 16'h1);
         chk("stall_nodone", 16'(instr_done), 16'h0);
         cyc();
      end
      mem_ready = 1'b1; #1;
      chk("stall_release", 16'(uc_step), 16'h1);
      chk("stall_release_nodone", 16'(instr_done), 16'h0);
      cyc();
      mem_ready = 1'b0; ctrl_word = cw(1, 0, 0, 0); #1;
      chk("stall_step2", 16'(uc_step), 16'h2);
      chk("stall_done", 16'(instr_done), 16'h1);
      cyc();
      ctrl_word = '0; #1;
      chk("stall_single_done", 16'(instr_done), 16'h0);

      // IRQ priority at END
      mem_data_in = 8'h00; mem_ready = 1'b1; #1;
      cyc();
      mem_ready = 1'b0; ctrl_word = cw(1, 0, 0, 0); ime = 1'b1; irq_pending = 5'b10100; #1;
      chk("irq_end_done", 16'(instr_done), 16'h1);
      chk("irq_end_noack", 16'(irq_ack), 16'h0);
      cyc();
      mem_ready = 1'b1; ctrl_word = '0; #1;
      chk("irq_ack", 16'(irq_ack), 16'h04);
      chk("irq_nofetch", 16'(fetch_req), 16'h0);
      chk("irq_noinc", 16'(pc_inc), 16'h0);
      cyc();
      mem_ready = 1'b0; ctrl_word = cw(1, 0, 0, 0); ime = 1'b0; #1;
      chk("irq_opcode", 16'(uc_opcode), 16'h0DD);
      chk("irq_step", 16'(uc_step), 16'h0);
      chk("irq_ack_clr", 16'(irq_ack), 16'h0);
      cyc();
      irq_pending = '0; ctrl_word = '0; #1;
      chk("irq_ret_fetch", 16'(fetch_req), 16'h1);

      // IRQ withdrawn during the IRQ cycle
      mem_data_in = 8'h00; mem_ready = 1'b1; #1;
      cyc();
      mem_ready = 1'b0; ctrl_word = cw(1, 0, 0, 0); ime = 1'b1; irq_pending = 5'b00010; #1;
      cyc();
      irq_pending = '0; ctrl_word = '0; #1;
      chk("irq_drop_noack", 16'(irq_ack), 16'h0);
      cyc();
      ime = 1'b0; #1;
      chk("irq_drop_fetch", 16'(fetch_req), 16'h1);

      // HALT, wake with ime=0
      mem_data_in = 8'h76; mem_ready = 1'b1; #1;
      cyc();
      mem_ready = 1'b0; ctrl_word = cw(0, 0, 1, 0); #1;
      chk("halt_done", 16'(instr_done), 16'h1);
      cyc();
      mem_ready = 1'b1; ctrl_word = '0; #1;
      chk("halted_nofetch", 16'(fetch_req), 16'h0);
      chk("halted_noinc", 16'(pc_inc), 16'h0);
      chk("halted_opcode", 16'(uc_opcode), 16'h076);
      cyc();
      irq_pending = 5'b00001; mem_ready = 1'b0; #1;
      chk("wake0_noack", 16'(irq_ack), 16'h0);
      cyc();
      #1;
      chk("wake0_fetch", 16'(fetch_req), 16'h1);
      chk("wake0_noack2", 16'(irq_ack), 16'h0);

      // HALT, wake with ime=1
      mem_data_in = 8'h76; mem_ready = 1'b1; #1;
      cyc();
      mem_ready = 1'b0; ctrl_word = cw(0, 0, 1, 0); #1;
      cyc();
      ctrl_word = '0; ime = 1'b1; #1;
      chk("wake1_halted", 16'(fetch_req), 16'h0);
      cyc();
      #1;
      chk("wake1_ack", 16'(irq_ack), 16'h01);
      cyc();
      ctrl_word = cw(1, 0, 0, 0); ime = 1'b0; irq_pending = '0; #1;
      chk("wake1_opcode", 16'(uc_opcode), 16'h0D3);
      cyc();

      // Step overflow, then reset mid-instruction
      mem_data_in = 8'h10; mem_ready = 1'b1; ctrl_word = '0; #1;
      cyc();
      mem_ready = 1'b0; ctrl_word = '0;
      for (int s = 0; s < 8; s++) begin
         #1;
         chk("ovf_step", 16'(uc_step), 16'(s));
         chk("ovf_noerr", 16'(ucode_err), 16'h0);
         cyc();
      end
      #1;
      chk("ovf_hold", 16'(uc_step), 16'h7);
      chk("ovf_err", 16'(ucode_err), 16'h1);
      cyc();
      #1;
      chk("ovf_hold2", 16'(uc_step), 16'h7);
      chk("ovf_err_sticky", 16'(ucode_err), 16'h1);
      reset_n = 1'b0; mem_ready = 1'b1; #1;
      chk("mid_rst_nofetch", 16'(fetch_req), 16'h0);
      chk("mid_rst_noinc", 16'(pc_inc), 16'h0);
      cyc();
      reset_n = 1'b1; mem_ready = 1'b0; #1;
      chk("mid_rst_step", 16'(uc_step), 16'h0);
      chk("mid_rst_err", 16'(ucode_err), 16'h0);
      chk("mid_rst_opcode", 16'(uc_opcode), 16'h000);
      chk("mid_rst_fetch", 16'(fetch_req), 16'h1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
